// File: rtl/secure_hdr_unwrap_pkg.sv
// Shared types for the header unwrap datapath: controller states and status codes.
package secure_hdr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KX,
        S_SC,
        S_VF,
        S_OUT
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_SIGFAIL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/hdr_timeout_ctr.sv
// Per-engine wait timer: cleared by the start pulse, flags when the wait budget is used up.
module hdr_timeout_ctr #(
    parameter int unsigned TO_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int unsigned   CW   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

    logic [CW-1:0] cnt;

    // Counts wait cycles after the start cycle; saturates on the last allowed cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load || !run) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The start cycle itself never expires; a done sampled on the expiry edge is handled first by the caller.
    assign expired = run && !load && (cnt == LAST);

endmodule

// File: rtl/secure_hdr_unwrap.sv
// Header unwrap controller: sequences key-unwrap, stream decrypt and signature verify engines.
module secure_hdr_unwrap
    import secure_hdr_pkg::*;
#(
    parameter int unsigned HDR_W  = 128,
    parameter int unsigned CK_W   = 64,
    parameter int unsigned CK_LSB = 5,
    parameter int unsigned KEY_W  = 32,
    parameter int unsigned PW     = 32,
    parameter int unsigned NW     = 1,
    parameter int unsigned PL_LSB = 69,
    parameter int unsigned DK_W   = 7,
    parameter int unsigned SIG_W  = 7,
    parameter int unsigned TO_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [HDR_W-1:0]  hdr_data,
    input  logic [DK_W-1:0]   priv_key,
    output logic              kx_start,
    output logic [CK_W-1:0]   kx_c,
    output logic [DK_W-1:0]   kx_d,
    input  logic              kx_done,
    input  logic [KEY_W-1:0]  kx_key,
    output logic              sc_start,
    output logic [KEY_W-1:0]  sc_key,
    output logic [PW-1:0]     sc_din,
    input  logic              sc_done,
    input  logic [PW-1:0]     sc_dout,
    output logic              vf_start,
    output logic [SIG_W-1:0]  vf_r,
    output logic [SIG_W-1:0]  vf_s,
    output logic [KEY_W-1:0]  vf_key,
    input  logic              vf_done,
    input  logic              vf_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NW*PW-1:0]  out_data,
    output logic [1:0]        out_status
);

    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

    if (CK_LSB + CK_W > HDR_W) begin : g_bad_ck
        $error("wrapped-key field exceeds header width");
    end
    if (PL_LSB + NW * PW > HDR_W) begin : g_bad_pl
        $error("payload field exceeds header width");
    end
    if (2 * SIG_W > PW) begin : g_bad_sig
        $error("signature fields exceed payload word width");
    end

    state_t            state;
    logic [HDR_W-1:0]  hdr_q;
    logic [DK_W-1:0]   dk_q;
    logic [KEY_W-1:0]  skey;
    logic [IW-1:0]     idx;
    logic              expired;
    logic              run;
    logic              unused_hdr;

    assign run = (state == S_KX) || (state == S_SC) || (state == S_VF);

    hdr_timeout_ctr #(
        .TO_CYC (TO_CYC)
    ) u_to (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (kx_start | sc_start | vf_start),
        .run     (run),
        .expired (expired)
    );

    assign kx_c       = hdr_q[CK_LSB +: CK_W];
    assign kx_d       = dk_q;
    assign sc_key     = skey;
    assign sc_din     = hdr_q[PL_LSB + int'(idx) * PW +: PW];
    assign vf_r       = out_data[SIG_W-1:0];
    assign vf_s       = out_data[2*SIG_W-1:SIG_W];
    assign vf_key     = skey;
    assign unused_hdr = ^hdr_q;

    // Controller: start pulses are registered one-cycle pulses; a done coinciding with its own start is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hdr_ready  <= 1'b0;
            hdr_q      <= '0;
            dk_q       <= '0;
            skey       <= '0;
            idx        <= '0;
            kx_start   <= 1'b0;
            sc_start   <= 1'b0;
            vf_start   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_status <= ST_OK;
        end else begin
            kx_start <= 1'b0;
            sc_start <= 1'b0;
            vf_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    hdr_ready <= 1'b1;
                    if (hdr_valid && hdr_ready) begin
                        hdr_q     <= hdr_data;
                        dk_q      <= priv_key;
                        hdr_ready <= 1'b0;
                        kx_start  <= 1'b1;
                        state     <= S_KX;
                    end
                end
                S_KX: begin
                    if (kx_done && !kx_start) begin
                        skey     <= kx_key;
                        idx      <= '0;
                        sc_start <= 1'b1;
                        state    <= S_SC;
                    end else if (expired) begin
                        out_status <= ST_TIMEOUT;
                        out_data   <= '0;
                        out_valid  <= 1'b1;
                        state      <= S_OUT;
                    end
                end
                S_SC: begin
                    if (sc_done && !sc_start) begin
                        out_data[int'(idx) * PW +: PW] <= sc_dout;
                        if (idx == IW'(NW - 1)) begin
                            vf_start <= 1'b1;
                            state    <= S_VF;
                        end else begin
                            idx      <= idx + 1'b1;
                            sc_start <= 1'b1;
                        end
                    end else if (expired) begin
                        out_status <= ST_TIMEOUT;
                        out_data   <= '0;
                        out_valid  <= 1'b1;
                        state      <= S_OUT;
                    end
                end
                S_VF: begin
                    if (vf_done && !vf_start) begin
                        out_status <= vf_ok ? ST_OK : ST_SIGFAIL;
                        out_valid  <= 1'b1;
                        state      <= S_OUT;
                    end else if (expired) begin
                        out_status <= ST_TIMEOUT;
                        out_data   <= '0;
                        out_valid  <= 1'b1;
                        state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        out_data   <= '0;
                        out_status <= ST_OK;
                        hdr_q      <= '0;
                        dk_q       <= '0;
                        skey       <= '0;
                        idx        <= '0;
                        hdr_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
